// File: rtl/exu_ctl.sv
// Execute-stage sequencer: latches a decoded op, runs the shared ALU for ALU_LAT cycles,
// resolves jump/branch/trap redirects and holds the result for the LSU. Optional: EXU_CTL_PERF_EN.
module exu_ctl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ARGS_WIDTH = 4,
  parameter int                    ALU_LAT    = 1,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VEC   = '0,
  parameter logic [ARGS_WIDTH-1:0] JMP_J      = 1,
  parameter logic [ARGS_WIDTH-1:0] JMP_B      = 2,
  parameter logic [ARGS_WIDTH-1:0] JMP_E      = 3
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_exu_flush,
  input  logic                  i_idu_valid,
  output logic                  o_idu_ready,
  input  logic [ADDR_WIDTH-1:0] i_idu_pc,
  input  logic [ARGS_WIDTH-1:0] i_idu_alu_type,
  input  logic [ARGS_WIDTH-1:0] i_idu_jmp_type,
  input  logic [DATA_WIDTH-1:0] i_idu_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_idu_jmp_or_reg_data,
  output logic [ARGS_WIDTH-1:0] o_alu_type,
  output logic [DATA_WIDTH-1:0] o_alu_rs1_data,
  output logic [DATA_WIDTH-1:0] o_alu_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_alu_res,
  output logic                  o_exu_valid,
  input  logic                  i_lsu_ready,
  output logic [ADDR_WIDTH-1:0] o_exu_pc,
  output logic [DATA_WIDTH-1:0] o_exu_res,
  output logic                  o_exu_jmp_en,
  output logic [ADDR_WIDTH-1:0] o_exu_jmp_pc,
  output logic                  o_exu_busy
`ifdef EXU_CTL_PERF_EN
  ,
  output logic [31:0]           o_perf_stall_cnt,
  output logic [31:0]           o_perf_op_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ARGS_WIDTH-1:0]   alu_type_q, jmp_type_q;
  logic [DATA_WIDTH-1:0]   rs1_q, rs2_q, off_q, res_q;
  logic                    taken_q;
  logic [ADDR_WIDTH-1:0]   target_q;
  logic                    load, capture, lsu_hs;
  logic                    jmp_hit;
  logic [ADDR_WIDTH-1:0]   jmp_tgt;

  assign o_exu_valid    = (state_q == DONE) && !i_exu_flush;
  assign lsu_hs         = o_exu_valid && i_lsu_ready;
  assign o_exu_res      = o_exu_valid ? res_q : '0;
  assign o_exu_pc       = pc_q;
  assign o_exu_jmp_en   = lsu_hs && taken_q;
  assign o_exu_jmp_pc   = o_exu_jmp_en ? target_q : '0;
  assign o_exu_busy     = (state_q != IDLE);
  assign o_alu_type     = alu_type_q;
  assign o_alu_rs1_data = rs1_q;
  assign o_alu_rs2_data = rs2_q;

  always_comb begin
    jmp_hit = 1'b0;
    jmp_tgt = '0;
    if (jmp_type_q == JMP_J) begin
      jmp_hit = 1'b1;
      jmp_tgt = ADDR_WIDTH'(i_alu_res);
    end else if (jmp_type_q == JMP_B) begin
      jmp_hit = (i_alu_res == DATA_WIDTH'(1));
      jmp_tgt = pc_q + ADDR_WIDTH'(off_q);
    end else if (jmp_type_q == JMP_E) begin
      jmp_hit = 1'b1;
      jmp_tgt = TRAP_VEC;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_idu_ready = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        o_idu_ready = 1'b1;
        if (i_idu_valid) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_lsu_ready) begin
          // a taken redirect blocks the wrong-path op offered in the same cycle
          o_idu_ready = !taken_q;
          if (!taken_q && i_idu_valid) begin
            load    = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_exu_flush) begin
      state_d     = IDLE;
      o_idu_ready = 1'b0;
      load        = 1'b0;
      capture     = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      alu_type_q <= '0;
      jmp_type_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      off_q      <= '0;
      res_q      <= '0;
      taken_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        pc_q       <= i_idu_pc;
        alu_type_q <= i_idu_alu_type;
        jmp_type_q <= i_idu_jmp_type;
        rs1_q      <= i_idu_rs1_data;
        rs2_q      <= i_idu_rs2_data;
        off_q      <= i_idu_jmp_or_reg_data;
        cnt_q      <= 4'(ALU_LAT - 1);
      end else if (state_q == EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        res_q    <= i_alu_res;
        taken_q  <= jmp_hit;
        target_q <= jmp_tgt;
      end
    end
  end

`ifdef EXU_CTL_PERF_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_perf_stall_cnt <= '0;
      o_perf_op_cnt    <= '0;
    end else begin
      if (state_q == DONE && !i_lsu_ready) o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
      if (lsu_hs) o_perf_op_cnt <= o_perf_op_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_ctl.sv
// Directed bench for exu_ctl: cycle table on an ALU_LAT=1 instance plus hand sequences
// for the ALU_LAT=3 stall case and reset in DONE.
module tb_exu_ctl;

  localparam logic [3:0]  JT_N = 4'd0, JT_J = 4'd1, JT_B = 4'd2, JT_E = 4'd3;
  localparam logic [31:0] TRAP = 32'h0000_0040;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        idu_valid = 1'b0, lsu_ready = 1'b0;
  logic [31:0] idu_pc = '0, rs1 = '0, rs2 = '0, off = '0, alu_res = '0;
  logic [3:0]  alu_type = '0, jmp_type = '0;

  logic        r1_rdy, r1_ev, r1_je, r1_busy;
  logic [3:0]  r1_atype;
  logic [31:0] r1_a1, r1_a2, r1_pc, r1_res, r1_jpc;
  logic        r3_rdy, r3_ev, r3_je, r3_busy;
  logic [3:0]  r3_atype;
  logic [31:0] r3_a1, r3_a2, r3_pc, r3_res, r3_jpc;
`ifdef EXU_CTL_PERF_EN
  logic [31:0] r1_stall, r1_ops, r3_stall, r3_ops;
`endif

  always #5 clk = ~clk;

  exu_ctl #(.ALU_LAT(1), .TRAP_VEC(TRAP)) dut1 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_exu_flush(flush),
    .i_idu_valid(idu_valid), .o_idu_ready(r1_rdy), .i_idu_pc(idu_pc),
    .i_idu_alu_type(alu_type), .i_idu_jmp_type(jmp_type),
    .i_idu_rs1_data(rs1), .i_idu_rs2_data(rs2), .i_idu_jmp_or_reg_data(off),
    .o_alu_type(r1_atype), .o_alu_rs1_data(r1_a1), .o_alu_rs2_data(r1_a2),
    .i_alu_res(alu_res), .o_exu_valid(r1_ev), .i_lsu_ready(lsu_ready),
    .o_exu_pc(r1_pc), .o_exu_res(r1_res), .o_exu_jmp_en(r1_je),
    .o_exu_jmp_pc(r1_jpc), .o_exu_busy(r1_busy)
`ifdef EXU_CTL_PERF_EN
    , .o_perf_stall_cnt(r1_stall), .o_perf_op_cnt(r1_ops)
`endif
  );

  exu_ctl #(.ALU_LAT(3), .TRAP_VEC(TRAP)) dut3 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_exu_flush(flush),
    .i_idu_valid(idu_valid), .o_idu_ready(r3_rdy), .i_idu_pc(idu_pc),
    .i_idu_alu_type(alu_type), .i_idu_jmp_type(jmp_type),
    .i_idu_rs1_data(rs1), .i_idu_rs2_data(rs2), .i_idu_jmp_or_reg_data(off),
    .o_alu_type(r3_atype), .o_alu_rs1_data(r3_a1), .o_alu_rs2_data(r3_a2),
    .i_alu_res(alu_res), .o_exu_valid(r3_ev), .i_lsu_ready(lsu_ready),
    .o_exu_pc(r3_pc), .o_exu_res(r3_res), .o_exu_jmp_en(r3_je),
    .o_exu_jmp_pc(r3_jpc), .o_exu_busy(r3_busy)
`ifdef EXU_CTL_PERF_EN
    , .o_perf_stall_cnt(r3_stall), .o_perf_op_cnt(r3_ops)
`endif
  );

  typedef struct {
    logic        v;
    logic [3:0]  jt;
    logic [31:0] pc, off, ares;
    logic        lr, fl;
    logic        rdy, ev;
    logic [31:0] res;
    logic        je;
    logic [31:0] jpc, epc;
  } vec_t;

  vec_t tab[32];
  int   nrows = 0;
  int   n_vec = 0, n_err = 0;

  task automatic add(input logic v, input logic [3:0] jt, input logic [31:0] pc, o, ar,
                     input logic lr, fl, rdy, ev, input logic [31:0] res,
                     input logic je, input logic [31:0] jpc, epc);
    tab[nrows] = '{v, jt, pc, o, ar, lr, fl, rdy, ev, res, je, jpc, epc};
    nrows++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //   v  jt    pc            off     ares      lr fl | rdy ev res       je jpc           epc
    add(1, JT_N, 32'h100,      0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      32'h15,   1, 0,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  1, 32'h15,   0, 0,            32'h100);
    add(1, JT_B, 32'h8000_0010, 32'h20, 0,       0, 0,   1,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      1,        0, 0,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        0, 0,   0,  1, 1,        0, 0,            32'h8000_0010);
    add(1, JT_N, 32'h900,      0,      0,        1, 0,   0,  1, 1,        1, 32'h8000_0030, 32'h8000_0010);
    add(1, JT_B, 32'h8000_0010, 32'h20, 0,       1, 0,   1,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  1, 0,        0, 0,            32'h8000_0010);
    add(1, JT_J, 32'h200,      0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      32'h1234, 1, 0,   0,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'ha00,      0,      0,        1, 0,   0,  1, 32'h1234, 1, 32'h1234,     32'h200);
    add(1, JT_E, 32'h300,      0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      32'h77,   1, 0,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   0,  1, 32'h77,   1, TRAP,         32'h300);
    add(1, JT_N, 32'h400,      0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(1, JT_N, 0,            0,      0,        1, 1,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'h480,      0,      0,        1, 1,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'h500,      0,      0,        1, 0,   1,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'h504,      0,      32'ha1,   1, 0,   0,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'h504,      0,      0,        1, 0,   1,  1, 32'ha1,   0, 0,            32'h500);
    add(1, JT_N, 32'h508,      0,      32'ha2,   1, 0,   0,  0, 0,        0, 0,            0);
    add(1, JT_N, 32'h508,      0,      0,        1, 0,   1,  1, 32'ha2,   0, 0,            32'h504);
    add(0, JT_N, 0,            0,      32'ha3,   1, 0,   0,  0, 0,        0, 0,            0);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  1, 32'ha3,   0, 0,            32'h508);
    add(0, JT_N, 0,            0,      0,        1, 0,   1,  0, 0,        0, 0,            0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst rdy", 32'(r1_rdy), 1);
    chk("rst ev", 32'(r1_ev), 0);
    chk("rst busy", 32'(r1_busy), 0);
    chk("rst res", r1_res, 0);
    chk("rst jpc", r1_jpc, 0);
    chk("rst alu_rs1", r1_a1, 0);
    chk("rst pc", r1_pc, 0);
    next_cycle();

    for (int i = 0; i < nrows; i++) begin
      idu_valid = tab[i].v;  jmp_type = tab[i].jt; idu_pc = tab[i].pc;
      off = tab[i].off;      alu_res = tab[i].ares; lsu_ready = tab[i].lr;
      flush = tab[i].fl;
      @(negedge clk);
      chk($sformatf("row%0d rdy", i), 32'(r1_rdy), 32'(tab[i].rdy));
      chk($sformatf("row%0d ev", i), 32'(r1_ev), 32'(tab[i].ev));
      chk($sformatf("row%0d res", i), r1_res, tab[i].res);
      chk($sformatf("row%0d jmp_en", i), 32'(r1_je), 32'(tab[i].je));
      chk($sformatf("row%0d jmp_pc", i), r1_jpc, tab[i].jpc);
      if (tab[i].ev) chk($sformatf("row%0d pc", i), r1_pc, tab[i].epc);
      next_cycle();
    end
    idu_valid = 1'b0; flush = 1'b0; jmp_type = JT_N;
`ifdef EXU_CTL_PERF_EN
    chk("perf stall", r1_stall, 1);
    chk("perf ops", r1_ops, 8);
`endif

    // ALU_LAT=3: operands stable through EXEC, result held across a 5-cycle LSU stall
    rst_n = 1'b0;
    next_cycle();
`ifdef EXU_CTL_PERF_EN
    chk("perf stall after reset", r1_stall, 0);
    chk("perf ops after reset", r1_ops, 0);
`endif
    rst_n = 1'b1;
    next_cycle();
    idu_valid = 1'b1; idu_pc = 32'h600; rs1 = 32'h11; rs2 = 32'h22;
    alu_type = 4'd5; lsu_ready = 1'b0;
    @(negedge clk);
    chk("lat3 accept rdy", 32'(r3_rdy), 1);
    next_cycle();
    idu_valid = 1'b0; rs1 = 32'hdead; rs2 = 32'hbeef; alu_type = 4'd9; idu_pc = 32'hfff;
    for (int k = 0; k < 3; k++) begin
      alu_res = (k == 2) ? 32'h99 : 32'hbad;
      @(negedge clk);
      chk($sformatf("lat3 exec%0d ev", k), 32'(r3_ev), 0);
      chk($sformatf("lat3 exec%0d rdy", k), 32'(r3_rdy), 0);
      chk($sformatf("lat3 exec%0d rs1", k), r3_a1, 32'h11);
      chk($sformatf("lat3 exec%0d rs2", k), r3_a2, 32'h22);
      chk($sformatf("lat3 exec%0d type", k), 32'(r3_atype), 5);
      next_cycle();
    end
    alu_res = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat3 stall%0d ev", k), 32'(r3_ev), 1);
      chk($sformatf("lat3 stall%0d res", k), r3_res, 32'h99);
      chk($sformatf("lat3 stall%0d pc", k), r3_pc, 32'h600);
      chk($sformatf("lat3 stall%0d rdy", k), 32'(r3_rdy), 0);
      next_cycle();
    end
    lsu_ready = 1'b1;
    @(negedge clk);
    chk("lat3 hs ev", 32'(r3_ev), 1);
    chk("lat3 hs res", r3_res, 32'h99);
    chk("lat3 hs rdy", 32'(r3_rdy), 1);
    next_cycle();
    @(negedge clk);
    chk("lat3 after hs ev", 32'(r3_ev), 0);
    chk("lat3 after hs busy", 32'(r3_busy), 0);
`ifdef EXU_CTL_PERF_EN
    chk("lat3 perf stall", r3_stall, 5);
    chk("lat3 perf ops", r3_ops, 1);
`endif
    next_cycle();

    // reset asserted while a taken jump waits in DONE
    idu_valid = 1'b1; jmp_type = JT_J; idu_pc = 32'h700; lsu_ready = 1'b0;
    next_cycle();
    idu_valid = 1'b0; alu_res = 32'h7700;
    next_cycle();
    alu_res = 32'h0;
    @(negedge clk);
    chk("rstdone ev before", 32'(r1_ev), 1);
    chk("rstdone je before", 32'(r1_je), 0);
    next_cycle();
    lsu_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstdone ev", 32'(r1_ev), 0);
    chk("rstdone je", 32'(r1_je), 0);
    chk("rstdone jpc", r1_jpc, 0);
    chk("rstdone busy", 32'(r1_busy), 0);
`ifdef EXU_CTL_PERF_EN
    chk("rstdone perf ops", r1_ops, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post rst rdy", 32'(r1_rdy), 1);
    chk("post rst ev", 32'(r1_ev), 0);
    chk("post rst je", 32'(r1_je), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exu_ctl.md
Name: exu_ctl

Overview:
- Execute-stage sequencer between IDU and LSU/WBU.
- Accepts one decoded op per valid/ready handshake and latches its operands.
- Drives the shared ALU for a configurable number of cycles, captures the result, and resolves jump/branch/trap redirects.
- Holds the result until downstream accepts it; supports back-to-back issue and flush.

Parameters:
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, operand/result width
ARGS_WIDTH, 4, width of alu_type and jmp_type codes (cfg encodings JMP_J/JMP_B/JMP_E)
ALU_LAT, 1, ALU cycles per op; legal range 1..15
TRAP_VEC, 32'h0, redirect target for JMP_E

Ports:
i_sys_clk  in  1  clock, rising edge
i_sys_rst_n  in  1  asynchronous active-low reset
i_exu_flush  in  1  synchronous flush, kills in-flight op
i_idu_valid  in  1  IDU has a decoded op
o_idu_ready  out  1  exu_ctl accepts op this cycle
i_idu_pc  in  ADDR_WIDTH  op PC
i_idu_alu_type  in  ARGS_WIDTH  ALU op code
i_idu_jmp_type  in  ARGS_WIDTH  jump class
i_idu_rs1_data  in  DATA_WIDTH  operand 1
i_idu_rs2_data  in  DATA_WIDTH  operand 2
i_idu_jmp_or_reg_data  in  DATA_WIDTH  branch offset
o_alu_type  out  ARGS_WIDTH  latched op code to ALU
o_alu_rs1_data  out  DATA_WIDTH  latched operand 1 to ALU
o_alu_rs2_data  out  DATA_WIDTH  latched operand 2 to ALU
i_alu_res  in  DATA_WIDTH  ALU result
o_exu_valid  out  1  result valid to LSU
i_lsu_ready  in  1  LSU accepts result
o_exu_pc  out  ADDR_WIDTH  PC of result op
o_exu_res  out  DATA_WIDTH  result; zero when o_exu_valid=0
o_exu_jmp_en  out  1  one-cycle redirect pulse
o_exu_jmp_pc  out  ADDR_WIDTH  redirect target; zero when jmp_en=0
o_exu_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_sys_rst_n=0):
  - State IDLE; all latches zero, counter zero.
  - Outputs: o_idu_ready=1 once out of reset; all other outputs 0.
  - Reset mid-op discards the op with no valid and no jmp pulse.
- FSM states IDLE, EXEC, DONE.
- IDLE:
  - o_idu_ready=1.
  - Handshake (i_idu_valid & o_idu_ready): latch pc, alu_type, jmp_type, rs1, rs2, offset; cnt<=ALU_LAT-1; go to EXEC.
- EXEC:
  - o_alu_* driven from latches, stable for the whole op.
  - Each cycle with cnt!=0: cnt decrements.
  - cnt==0: res<=i_alu_res, resolve jump, go to DONE.
- Jump resolve (registered at EXEC exit):
  - JMP_J: taken, target = i_alu_res.
  - JMP_B: taken iff i_alu_res==1, target = pc + offset, mod 2^ADDR_WIDTH with wrap.
  - JMP_E: taken, target = TRAP_VEC.
  - Other codes: not taken.
- DONE:
  - o_exu_valid=1; o_exu_res and o_exu_pc held stable until i_lsu_ready.
  - Jump taken: o_exu_jmp_en=1 and o_exu_jmp_pc=target only in the handshake cycle (o_exu_valid & i_lsu_ready), never before.
  - Handshake with no jump taken: o_idu_ready=1 in the same cycle. A new op offered then is accepted, going straight to EXEC (back-to-back); otherwise go to IDLE.
  - Handshake with jump taken: o_idu_ready=0 that cycle (wrong path blocked); go to IDLE.
  - No handshake: stay in DONE with o_idu_ready=0.
- Latency: accept at cycle T -> o_exu_valid at T+ALU_LAT+1.
- Throughput: one op per ALU_LAT+1 cycles with i_lsu_ready held high.
- i_exu_flush has highest priority:
  - Next state IDLE; o_idu_ready=0 and o_exu_valid=0 in the flush cycle; no jmp pulse.
  - An op offered in the flush cycle is not accepted.
- Gating: o_exu_valid is registered state-based, not combinational on i_lsu_ready. o_alu_* keep their last values while in IDLE.

Optional Feature:
- Macro: EXU_CTL_PERF_EN.
- Defined:
  - Adds output o_perf_stall_cnt (32 bits): counts cycles in DONE with i_lsu_ready=0.
  - Adds output o_perf_op_cnt (32 bits): counts completed LSU handshakes.
  - Both reset to 0, wrap at 2^32, and are unaffected by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ALU_LAT=1, add op at cycle 0, i_alu_res=32'h15, i_lsu_ready=1 -> o_exu_valid=1 with res=32'h15 at cycle 2; o_exu_jmp_en=0.
- JMP_B, pc=32'h8000_0010, offset=32'h20, i_alu_res=1 -> jmp_en pulse with jmp_pc=32'h8000_0030 in the handshake cycle only. Same op with i_alu_res=0 -> jmp_en stays 0.
- ALU_LAT=3, i_lsu_ready=0 for 5 cycles after valid -> res/pc held stable, o_idu_ready=0. Then ready=1 -> single handshake.
- Back-to-back non-jump ops with i_idu_valid and i_lsu_ready held high, ALU_LAT=1 -> valid every 2 cycles, no op lost or duplicated.
- JMP_J taken while IDU offers the next op in the handshake cycle -> next op not accepted (o_idu_ready=0). JMP_E -> jmp_pc=TRAP_VEC.
- i_exu_flush in EXEC, and separately i_sys_rst_n low in DONE -> IDLE, no valid, no jmp pulse. With EXU_CTL_PERF_EN, counters: flush leaves them unchanged, reset clears them.
